// File: rtl/ibex_xif_mem_responder.sv
// ibex_xif_mem_responder: fixed-latency in-order RAM responder for the Ibex req/gnt/rvalid bus (err on out-of-range with IBEX_XIF_MEM_RESP_ERR_EN).
module ibex_xif_mem_responder #(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned IntgWidth = 7,
  parameter int unsigned MemDepth = 1024,
  parameter logic [AddrWidth-1:0] BaseAddr = '0,
  parameter int unsigned Latency = 2,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  output logic                   gnt_o,
  input  logic [AddrWidth-1:0]   addr_i,
  input  logic                   we_i,
  input  logic [DataWidth/8-1:0] be_i,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [IntgWidth-1:0]   wintg_i,
  output logic                   rvalid_o,
  output logic [DataWidth-1:0]   rdata_o,
  output logic [IntgWidth-1:0]   rintg_o,
  output logic                   err_o
);
  localparam int unsigned IdxW = $clog2(MemDepth);
  localparam int unsigned PtrW = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
  localparam int unsigned AgeW = $clog2(Latency + 1);
  localparam int unsigned BeW = DataWidth / 8;
  logic [DataWidth-1:0] mem_q [MemDepth];
  logic [IntgWidth-1:0] mintg_q [MemDepth];
  logic [DataWidth-1:0] fdata_q [MaxOutstanding];
  logic [IntgWidth-1:0] fintg_q [MaxOutstanding];
  logic [AgeW-1:0] age_q [MaxOutstanding];
  logic [MaxOutstanding-1:0] ferr_q;
  logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [AddrWidth-1:0] off;
  logic [IdxW-1:0] idx;
  logic oor, push, pop, wr_en;
  logic [DataWidth-1:0] rd_word, wr_word;
  always_comb begin
    off = addr_i - BaseAddr;
    idx = IdxW'(off >> 2);
`ifdef IBEX_XIF_MEM_RESP_ERR_EN
    oor = (addr_i < BaseAddr) || ({1'b0, off} >= (AddrWidth+1)'(4 * MemDepth));
`else
    oor = 1'b0;
`endif
    gnt_o = req_i && (count_q < CntW'(MaxOutstanding));
    push = req_i && gnt_o;
    wr_en = push && we_i && !oor;
    rd_word = mem_q[idx];
    wr_word = rd_word;
    for (int b = 0; b < BeW; b++) wr_word[8*b +: 8] = be_i[b] ? wdata_i[8*b +: 8] : rd_word[8*b +: 8];
    // the oldest entry is always the head, so only it can have reached Latency
    rvalid_o = (count_q != '0) && (age_q[rptr_q] == AgeW'(Latency));
    pop = rvalid_o;
    rdata_o = rvalid_o ? fdata_q[rptr_q] : '0;
    rintg_o = rvalid_o ? fintg_q[rptr_q] : '0;
    err_o = rvalid_o && ferr_q[rptr_q];
    wptr_d = !push ? wptr_q : (wptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wptr_q + PtrW'(1);
    rptr_d = !pop ? rptr_q : (rptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rptr_q + PtrW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MemDepth; i++) begin
        mem_q[i] <= '0;
        mintg_q[i] <= '0;
      end
      for (int i = 0; i < MaxOutstanding; i++) begin
        fdata_q[i] <= '0;
        fintg_q[i] <= '0;
        age_q[i] <= '0;
      end
      ferr_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
    end else begin
      if (wr_en) begin
        mem_q[idx] <= wr_word;
        mintg_q[idx] <= wintg_i;
      end
      for (int i = 0; i < MaxOutstanding; i++)
        age_q[i] <= (age_q[i] == AgeW'(Latency)) ? age_q[i] : age_q[i] + AgeW'(1);
      if (push) begin
        fdata_q[wptr_q] <= (we_i || oor) ? '0 : rd_word;
        fintg_q[wptr_q] <= (we_i || oor) ? '0 : mintg_q[idx];
        ferr_q[wptr_q] <= oor;
        age_q[wptr_q] <= AgeW'(1);
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
    end
  end
endmodule

// File: tb/tb_ibex_xif_mem_responder.sv
// tb_ibex_xif_mem_responder: scoreboard bench for the default responder plus a Latency=4/MaxOutstanding=2 instance.
module tb_ibex_xif_mem_responder;
  localparam int LAT = 2;
  logic clk = 0;
  logic rst_n = 0;
  logic req = 0, we = 0, gnt, rvalid, err;
  logic [31:0] addr = 0, wdata = 0, rdata;
  logic [3:0] be = 0;
  logic [6:0] wintg = 0, rintg;
  logic l_req = 0, l_we = 0, l_gnt, l_rvalid, l_err;
  logic [31:0] l_addr = 0, l_wdata = 0, l_rdata;
  logic [3:0] l_be = 0;
  logic [6:0] l_wintg = 0, l_rintg;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  typedef struct {logic [31:0] d; logic [6:0] g; logic e; int due;} exp_t;
  exp_t sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  ibex_xif_mem_responder u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .wintg_i(wintg), .rvalid_o(rvalid), .rdata_o(rdata), .rintg_o(rintg), .err_o(err)
  );
  ibex_xif_mem_responder #(.Latency(4), .MaxOutstanding(2)) u_lim (
    .clk_i(clk), .rst_ni(rst_n), .req_i(l_req), .gnt_o(l_gnt), .addr_i(l_addr), .we_i(l_we), .be_i(l_be),
    .wdata_i(l_wdata), .wintg_i(l_wintg), .rvalid_o(l_rvalid), .rdata_o(l_rdata), .rintg_o(l_rintg), .err_o(l_err)
  );
  always @(negedge clk) begin
    exp_t e;
    n_cmp++;
    if (rvalid) begin
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_rvalid: got rdata %h rintg %h err %b, none pending", rdata, rintg, err);
      end else begin
        e = sb.pop_front();
        if (rdata !== e.d || rintg !== e.g || err !== e.e || cyc != e.due) begin
          n_bad++;
          $display("FAIL response: got %h/%h/%b at cycle %0d, expected %h/%h/%b at cycle %0d",
                   rdata, rintg, err, cyc, e.d, e.g, e.e, e.due);
        end
      end
    end else if (rdata !== 0 || rintg !== 0 || err !== 0) begin
      n_bad++;
      $display("FAIL idle_outputs: got %h/%h/%b with rvalid low, expected zeros", rdata, rintg, err);
    end
  end
  task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d,
                       input logic [6:0] g, input logic [31:0] ed, input logic [6:0] eg, input logic ee);
    exp_t e;
    bit ok = 0;
    req = 1; addr = a; we = w; be = b; wdata = d; wintg = g;
    for (int k = 0; k < 16 && !ok; k++) begin
      @(negedge clk);
      if (gnt) ok = 1;
      else begin @(posedge clk); #1; end
    end
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL grant: gnt_o never high for addr %h, expected a grant", a);
    end else begin
      e.d = ed; e.g = eg; e.e = ee; e.due = cyc + LAT;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req = 0; we = 0; be = 0;
  endtask
  task automatic drain;
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d responses still pending, expected 0", sb.size());
      sb.delete();
    end
  endtask
  task automatic test_reset;
    rst_n = 0; req = 0;
    #3;
    n_cmp++;
    if (gnt !== 0 || rvalid !== 0 || rdata !== 0 || rintg !== 0 || err !== 0) begin
      n_bad++;
      $display("FAIL reset_idle: gnt %b rvalid %b data %h intg %h err %b, expected all 0", gnt, rvalid, rdata, rintg, err);
    end
    req = 1;
    #1;
    n_cmp++;
    if (gnt !== 1) begin
      n_bad++;
      $display("FAIL reset_gnt: gnt %b with req high, expected 1", gnt);
    end
    req = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
  endtask
  task automatic test_single_write;
    issue(32'h10, 1, 4'hF, 32'hDEADBEEF, 7'h2A, 0, 0, 0);
    issue(32'h10, 0, 4'h0, 0, 0, 32'hDEADBEEF, 7'h2A, 0);
    drain();
  endtask
  task automatic test_partial_write;
    issue(32'h20, 1, 4'hF, 32'h11223344, 7'h05, 0, 0, 0);
    issue(32'h20, 1, 4'b0101, 32'hAABBCCDD, 7'h06, 0, 0, 0);
    issue(32'h20, 0, 4'h0, 0, 0, 32'h11BB33DD, 7'h06, 0);
    issue(32'h20, 1, 4'h0, 32'hFFFFFFFF, 7'h44, 0, 0, 0);
    issue(32'h20, 0, 4'h0, 0, 0, 32'h11BB33DD, 7'h44, 0);
    drain();
  endtask
  task automatic test_raw;
    issue(32'h30, 1, 4'hF, 32'h5, 7'h01, 0, 0, 0);
    issue(32'h30, 0, 4'h0, 0, 0, 32'h5, 7'h01, 0);
    issue(32'h33, 0, 4'h0, 0, 0, 32'h5, 7'h01, 0);
    drain();
  endtask
  task automatic test_oor;
    issue(32'h0, 1, 4'hF, 32'hCAFEF00D, 7'h11, 0, 0, 0);
    issue(32'hFFC, 1, 4'hF, 32'h600DF00D, 7'h22, 0, 0, 0);
    issue(32'hFFC, 0, 4'h0, 0, 0, 32'h600DF00D, 7'h22, 0);
`ifdef IBEX_XIF_MEM_RESP_ERR_EN
    issue(32'h1000, 0, 4'h0, 0, 0, 0, 0, 1);
    issue(32'h1000, 1, 4'hF, 32'h12345678, 7'h33, 0, 0, 1);
    issue(32'h0, 0, 4'h0, 0, 0, 32'hCAFEF00D, 7'h11, 0);
`else
    issue(32'h1000, 0, 4'h0, 0, 0, 32'hCAFEF00D, 7'h11, 0);
    issue(32'h1000, 1, 4'hF, 32'h12345678, 7'h33, 0, 0, 0);
    issue(32'h0, 0, 4'h0, 0, 0, 32'h12345678, 7'h33, 0);
`endif
    drain();
  endtask
  task automatic test_limit;
    logic [5:0] eg = 6'b100011, ev = 6'b110000;
    int nxt = 0, nrv = 0;
    bit g;
    for (int k = 0; k < 3; k++) begin
      l_req = 1; l_we = 1; l_be = 4'hF; l_addr = 32'(k * 4); l_wdata = 32'h100 + 32'(k); l_wintg = 7'(k);
      @(negedge clk);
      n_cmp++;
      if (l_gnt !== 1) begin
        n_bad++;
        $display("FAIL limit_prewrite_gnt: gnt %b, expected 1", l_gnt);
      end
      @(posedge clk); #1;
      l_req = 0; l_we = 0;
      repeat (6) @(posedge clk);
      #1;
    end
    l_req = 1; l_addr = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      g = l_gnt;
      n_cmp++;
      if (l_gnt !== eg[c] || l_rvalid !== ev[c]) begin
        n_bad++;
        $display("FAIL limit_cycle%0d: gnt %b rvalid %b, expected gnt %b rvalid %b", c, l_gnt, l_rvalid, eg[c], ev[c]);
      end
      if (l_rvalid) begin
        n_cmp++;
        if (l_rdata !== 32'h100 + 32'(nrv) || l_rintg !== 7'(nrv)) begin
          n_bad++;
          $display("FAIL limit_order: rdata %h rintg %h, expected %h %h", l_rdata, l_rintg, 32'h100 + 32'(nrv), 7'(nrv));
        end
        nrv++;
      end
      @(posedge clk);
      if (g) nxt++;
      #1 l_addr = 32'(nxt * 4);
    end
    l_req = 0;
    for (int k = 0; k < 10 && nrv < 3; k++) begin
      @(negedge clk);
      if (l_rvalid) begin
        n_cmp++;
        if (l_rdata !== 32'h102 || l_rintg !== 7'h2 || k != 3) begin
          n_bad++;
          $display("FAIL limit_third: rdata %h rintg %h after %0d cycles, expected 00000102 02 after 3", l_rdata, l_rintg, k);
        end
        nrv++;
      end
    end
    n_cmp++;
    if (nrv != 3) begin
      n_bad++;
      $display("FAIL limit_count: %0d responses, expected 3", nrv);
    end
    @(posedge clk); #1;
  endtask
  task automatic test_reset_mid;
    issue(32'h40, 1, 4'hF, 32'h77, 7'h07, 0, 0, 0);
    drain();
    issue(32'h40, 0, 4'h0, 0, 0, 32'h77, 7'h07, 0);
    req = 1; addr = 32'h10; we = 0;
    @(negedge clk);
    n_cmp++;
    if (gnt !== 1) begin
      n_bad++;
      $display("FAIL mid_gnt: gnt %b, expected 1", gnt);
    end
    @(posedge clk);
    #2;
    n_cmp++;
    if (rvalid !== 1) begin
      n_bad++;
      $display("FAIL mid_pre: rvalid %b before reset, expected 1", rvalid);
    end
    rst_n = 0;
    sb.delete();
    #1;
    n_cmp++;
    if (rvalid !== 0 || rdata !== 0) begin
      n_bad++;
      $display("FAIL mid_async: rvalid %b rdata %h right after reset, expected 0 0", rvalid, rdata);
    end
    req = 0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    issue(32'h10, 0, 4'h0, 0, 0, 0, 0, 0);
    issue(32'h40, 0, 4'h0, 0, 0, 0, 0, 0);
    issue(32'h20, 0, 4'h0, 0, 0, 0, 0, 0);
    drain();
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_partial_write();
    test_raw();
    test_oor();
    test_limit();
    test_reset_mid();
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
